// File: rtl/qsim_pkg.sv
// rtl/qsim_pkg.sv - shared gate codes, FSM state type and gate-code check for the qsim sequencer
package qsim_pkg;

  typedef enum logic [3:0] {
    G_ZERO  = 4'd0,
    G_IDENT = 4'd1,
    G_X     = 4'd2,
    G_Y     = 4'd3,
    G_Z     = 4'd4,
    G_H     = 4'd5,
    G_S     = 4'd6,
    G_SDG   = 4'd7,
    G_T     = 4'd8,
    G_TDG   = 4'd9,
    G_SQRTX = 4'd10
  } gate_e;

  localparam int G_MAX = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic gate_code_ok(input logic [3:0] code);
    return int'(code) <= G_MAX;
  endfunction

endpackage

// File: rtl/bit_insert.sv
// rtl/bit_insert.sv - amplitude pair address generator: insert the target bit into the pair counter
// Ports: p (pair counter, NQ-1 bits), target (qubit index) ->
//   addr_a (target bit forced 0), addr_b (same address with target bit 1). Purely combinational.
module bit_insert #(
  parameter  int NQ = 4,
  localparam int TW = $clog2(NQ),
  localparam int AW = NQ
) (
  input  logic [NQ-2:0] p,
  input  logic [TW-1:0] target,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b
);

  logic [AW-1:0] p_ext;
  logic [AW-1:0] low_mask;
  logic [AW-1:0] tgt_bit;

  assign p_ext    = {1'b0, p};
  assign tgt_bit  = AW'(1) << target;
  // Bits of p below the target stay put; everything from the target up moves one place left.
  assign low_mask = tgt_bit - AW'(1);
  assign addr_a   = ((p_ext & ~low_mask) << 1) | (p_ext & low_mask);
  assign addr_b   = addr_a | tgt_bit;

endmodule

// File: rtl/gate_seq_ctrl.sv
// rtl/gate_seq_ctrl.sv - single-qubit gate sequencer: walks all amplitude pairs of one gate instruction
// Optional build macro: GATE_SEQ_SKIP_ID_EN (identity gates retire without issuing beats).
// Ports: clk, rst (synchronous, active high);
//   instr_valid/instr_ready/instr_gate/instr_target - instruction handshake;
//   gate_sel/row_sel/addr_a/addr_b/issue_valid/issue_ready - datapath beat handshake;
//   done - retire pulse, err - reject pulse, busy - not idle.
module gate_seq_ctrl
  import qsim_pkg::*;
#(
  parameter  int NQ = 4,
  localparam int TW = $clog2(NQ),
  localparam int AW = NQ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_gate,
  input  logic [TW-1:0] instr_target,
  output logic [3:0]    gate_sel,
  output logic          row_sel,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic          done,
  output logic          err,
  output logic          busy
);

  state_e        state_q;
  logic [3:0]    gate_q;
  logic [TW-1:0] tgt_q;
  logic [NQ-2:0] p_q;
  logic          row_q;
  logic          err_q;

  logic          instr_ok;
  logic          in_issue;
  logic [AW-1:0] pair_a;
  logic [AW-1:0] pair_b;

  assign instr_ok = gate_code_ok(instr_gate) && (int'(instr_target) < NQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gate_q  <= '0;
      tgt_q   <= '0;
      p_q     <= '0;
      row_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            if (!instr_ok) begin
              err_q <= 1'b1;
            end else begin
              gate_q <= instr_gate;
              tgt_q  <= instr_target;
              p_q    <= '0;
              row_q  <= 1'b0;
`ifdef GATE_SEQ_SKIP_ID_EN
              state_q <= (instr_gate == G_IDENT) ? S_DONE : S_ISSUE;
`else
              state_q <= S_ISSUE;
`endif
            end
          end
        end
        S_ISSUE: begin
          if (issue_ready) begin
            if (row_q) begin
              row_q <= 1'b0;
              // Last pair: leave p saturated rather than wrapping.
              if (p_q == '1) state_q <= S_DONE;
              else           p_q     <= p_q + 1'b1;
            end else begin
              row_q <= 1'b1;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  bit_insert #(.NQ(NQ)) u_bit_insert (
    .p      (p_q),
    .target (tgt_q),
    .addr_a (pair_a),
    .addr_b (pair_b)
  );

  // Outputs are qualified by rst so they read zero during the reset cycle itself.
  assign in_issue    = (state_q == S_ISSUE) && !rst;
  assign instr_ready = (state_q == S_IDLE) && !rst;
  assign issue_valid = in_issue;
  assign gate_sel    = in_issue ? gate_q : 4'd0;
  assign row_sel     = in_issue && row_q;
  assign addr_a      = in_issue ? pair_a : '0;
  assign addr_b      = in_issue ? pair_b : '0;
  assign done        = (state_q == S_DONE) && !rst;
  assign err         = err_q && !rst;
  assign busy        = (state_q != S_IDLE) && !rst;

endmodule
